sid_readback: RTL and testbench

- Read-side companion to the SID register writer: periodically reads the SID read-only registers POTX, POTY, OSC3 and ENV3 (0x19–0x1C) over the same SID bus.
- Latches the results into a small register file for the ESP host interface.
- Runs sweeps on request, paced by sid_clk (phi2).
- Yields the bus whenever the writer is active.

---
 rtl/sid_readback_pkg.sv | 17 +
 rtl/sid_readback_if.sv | 27 ++
 rtl/sid_clk_edge.sv | 18 +
 rtl/sid_readback.sv | 127 ++++++++++++
 tb/tb_sid_readback.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_readback_pkg.sv
// Shared SID definitions: read-only register addresses and the readback sweep state.
package sid_pkg;

   localparam logic [4:0] SID_POTX     = 5'd25;
   localparam logic [4:0] SID_POTY     = 5'd26;
   localparam logic [4:0] SID_OSC3     = 5'd27;
   localparam logic [4:0] SID_ENV3     = 5'd28;
   localparam logic [4:0] SID_NUM_REGS = 5'd29;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_POS,
      ACTIVE,
      DONE
   } sid_rb_state_e;

endpackage

// File: rtl/sid_readback_if.sv
// SID bus, writer arbitration and host register-file signals of the readback block.
interface sid_readback_if #(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2
);
   logic [4:0]          addr;
   logic                sid_cs;
   logic                sid_rw;
   logic [7:0]          sid_d_in;
   logic                req;
   logic                wr_busy;
   logic                busy;
   logic                done;
   logic [SEL_W-1:0]    rd_sel;
   logic [7:0]          rd_data;
   logic [NUM_REGS-1:0] rb_valid;

   modport master (
      output addr, sid_cs, sid_rw, busy, done, rd_data, rb_valid,
      input  sid_d_in, req, wr_busy, rd_sel
   );

   modport slave (
      input  addr, sid_cs, sid_rw, busy, done, rd_data, rb_valid,
      output sid_d_in, req, wr_busy, rd_sel
   );
endinterface

// File: rtl/sid_clk_edge.sv
// Registers phi2 in the clk domain and flags its rising/falling edges for one clk.
module sid_clk_edge (
   input  logic clk,
   input  logic rst,
   input  logic sid_clk,
   output logic pos,
   output logic neg
);
   logic sid_clk_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sid_clk_q <= 1'b0;
      else      sid_clk_q <= sid_clk;
   end

   assign pos = ~sid_clk_q &  sid_clk;
   assign neg =  sid_clk_q & ~sid_clk;
endmodule

// File: rtl/sid_readback.sv
// Sweeps the SID read-only registers into a host-visible register file, one per phi2 period.
// Optional change interrupt (irq, irq_ack, chg_mask) under SID_READBACK_CHANGE_IRQ_EN.
module sid_readback
   import sid_pkg::*;
#(
   parameter int FIRST_REG = SID_POTX,
   parameter int NUM_REGS  = 4,
   parameter int SEL_W     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sid_clk,
   sid_readback_if.master      bus
`ifdef SID_READBACK_CHANGE_IRQ_EN
   ,
   input  logic                irq_ack,
   output logic                irq,
   output logic [NUM_REGS-1:0] chg_mask
`endif
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   sid_rb_state_e             state, nxt;
   logic [IDX_W-1:0]          idx;
   logic                      pending;
   logic [7:0]                cap;
   logic [NUM_REGS-1:0][7:0]  value;
   logic [NUM_REGS-1:0]       rb_valid_q;
   logic                      sc_pos, sc_neg;
   logic                      start, capture, last;

   sid_clk_edge u_edge (
      .clk     (clk),
      .rst     (rst),
      .sid_clk (sid_clk),
      .pos     (sc_pos),
      .neg     (sc_neg)
   );

   assign last    = (idx == IDX_W'(NUM_REGS - 1));
   assign start   = (state == IDLE) && (nxt == WAIT_POS);
   assign capture = (state == ACTIVE) && sc_neg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // A bus cycle only opens on a phi2 rise with the writer idle; once open it always completes.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (pending && !bus.wr_busy) nxt = WAIT_POS;
         WAIT_POS: if (sc_pos && !bus.wr_busy)  nxt = ACTIVE;
         ACTIVE:   if (sc_neg)                  nxt = last ? DONE : WAIT_POS;
         DONE:                                  nxt = IDLE;
         default:                               nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.sid_cs = 1'b1;
      bus.sid_rw = 1'b1;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.addr   = 5'd0;
      case (state)
         WAIT_POS: begin
            bus.busy = 1'b1;
            bus.addr = 5'(FIRST_REG) + 5'(idx);
         end
         ACTIVE: begin
            bus.busy   = 1'b1;
            bus.sid_cs = 1'b0;
            bus.addr   = 5'(FIRST_REG) + 5'(idx);
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // cap keeps tracking the bus while phi2 is high, so the falling edge commits the latest sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         pending    <= 1'b0;
         cap        <= 8'd0;
         value      <= '0;
         rb_valid_q <= '0;
      end else begin
         pending <= bus.req | (pending & ~start);
         if (start)               idx <= '0;
         else if (capture && !last) idx <= idx + 1'b1;
         if (state == ACTIVE && sid_clk) cap <= bus.sid_d_in;
         if (capture) begin
            value[idx]      <= cap;
            rb_valid_q[idx] <= 1'b1;
         end
      end
   end

   assign bus.rb_valid = rb_valid_q;

   always_comb begin
      bus.rd_data = 8'd0;
      for (int i = 0; i < NUM_REGS; i++)
         if (bus.rd_sel == SEL_W'(i)) bus.rd_data = value[i];
   end

`ifdef SID_READBACK_CHANGE_IRQ_EN
   logic chg;
   assign chg = capture && rb_valid_q[idx] && (value[idx] != cap);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq      <= 1'b0;
         chg_mask <= '0;
      end else if (chg) begin
         irq           <= 1'b1;
         chg_mask[idx] <= 1'b1;
      end else if (irq_ack) begin
         irq      <= 1'b0;
         chg_mask <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_sid_readback.sv
// Randomized scoreboard bench for sid_readback: model SID, writer contention, coalescing, reset.
module tb_sid_readback;
   import sid_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] ph  = 4'd0;
   logic       sid_clk;

   always #5 clk = ~clk;
   always @(posedge clk) ph <= ph + 4'd1;
   assign sid_clk = ph[3];

   sid_readback_if #(.NUM_REGS(4), .SEL_W(2)) bus ();

`ifdef SID_READBACK_CHANGE_IRQ_EN
   logic       irq_ack = 1'b0;
   logic       irq;
   logic [3:0] chg_mask;
`endif

   sid_readback #(.FIRST_REG(25), .NUM_REGS(4), .SEL_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .sid_clk (sid_clk),
      .bus     (bus)
`ifdef SID_READBACK_CHANGE_IRQ_EN
      ,
      .irq_ack  (irq_ack),
      .irq      (irq),
      .chg_mask (chg_mask)
`endif
   );

   typedef struct packed {
      logic [3:0][7:0] v;
      logic [3:0]      rbv;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] mem [4];
   logic       late     = 1'b0;
   logic       rnd_busy = 1'b0;
   int         n_cmp = 0, n_bad = 0;
   int         done_cnt = 0, exp_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model SID: registers 25..28 return mem; late mode flips 0xAA->0x5A on the last phi2-high clk.
   always_comb begin
      bus.sid_d_in = 8'h00;
      if (late)
         bus.sid_d_in = (ph == 4'd15) ? 8'h5A : 8'hAA;
      else if (bus.addr >= 5'd25 && bus.addr <= 5'd28)
         bus.sid_d_in = mem[2'(bus.addr - 5'd25)];
   end

   // A completed sweep exposes whatever the SID presented and marks every register captured.
   function automatic exp_t snap();
      exp_t e;
      for (int i = 0; i < 4; i++) e.v[i] = late ? 8'h5A : mem[i];
      e.rbv = 4'hF;
      return e;
   endfunction

   always begin
      @(posedge clk); #1;
      if (rnd_busy && $urandom_range(0, 15) == 0) bus.wr_busy = ~bus.wr_busy;
   end

   // Monitor: bus-window checks and scoreboard pop on every done pulse.
   int   k = 0;
   logic cs_prev = 1'b1, done_prev = 1'b0, wb_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         k = 0; cs_prev = 1'b1; done_prev = 1'b0; wb_prev = bus.wr_busy;
      end else begin
         if (cs_prev && !bus.sid_cs) begin
            chk("cs_addr", 32'(bus.addr), 32'(25 + k));
            chk("cs_rw", 32'(bus.sid_rw), 32'd1);
            chk("cs_while_wr_busy", 32'(wb_prev), 32'd0);
            k++;
         end
         if (bus.done) begin
            chk("done_one_clk", 32'(done_prev), 32'd0);
            chk("done_busy", 32'(bus.busy), 32'd0);
            chk("done_windows", 32'(k), 32'd4);
            k = 0;
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL done_unexpected: got done expected none at %0t", $time);
            end else begin
               e = sbq.pop_front();
               chk("rb_valid", 32'(bus.rb_valid), 32'(e.rbv));
               for (int s = 0; s < 4; s++) begin
                  bus.rd_sel = 2'(s);
                  #1;
                  chk($sformatf("rd_data[%0d]", s), 32'(bus.rd_data), 32'(e.v[s]));
               end
            end
            done_cnt++;
         end
         cs_prev = bus.sid_cs; done_prev = bus.done; wb_prev = bus.wr_busy;
      end
   end

   task automatic pulse_req();
      @(posedge clk); #1 bus.req = 1'b1;
      @(posedge clk); #1 bus.req = 1'b0;
   endtask

   task automatic wait_done(input int add, input int budget);
      exp_done += add;
      for (int i = 0; i < budget && done_cnt < exp_done; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1 chk("done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   task automatic wait_cs(input logic lvl, input int budget, output int cyc);
      cyc = 0;
      while (bus.sid_cs !== lvl && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
   endtask

   initial begin
      int cyc, lowc;
      bus.req = 1'b0; bus.wr_busy = 1'b0; bus.rd_sel = 2'd0;
      rand_mem();
      repeat (3) @(posedge clk); #1;
      chk("rst_cs", 32'(bus.sid_cs), 32'd1);
      chk("rst_rw", 32'(bus.sid_rw), 32'd1);
      chk("rst_addr", 32'(bus.addr), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rb_valid", 32'(bus.rb_valid), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      #2 rst = 1'b1;

`ifdef SID_READBACK_CHANGE_IRQ_EN
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h10; mem[3] = 8'h04;
      sbq.push_back(snap()); pulse_req(); wait_done(1, 600);
      chk("irq_first_sweep", 32'(irq), 32'd0);
      mem[2] = 8'h20;
      sbq.push_back(snap()); pulse_req(); wait_done(1, 600);
      chk("irq_second_sweep", 32'(irq), 32'd1);
      chk("chg_mask", 32'(chg_mask), 32'h4);
      @(posedge clk); #1 irq_ack = 1'b1;
      @(posedge clk); #1 irq_ack = 1'b0;
      chk("irq_ack_irq", 32'(irq), 32'd0);
      chk("irq_ack_mask", 32'(chg_mask), 32'd0);
`endif

      // basic sweep
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      sbq.push_back(snap()); pulse_req(); wait_done(1, 600);

      // random data under random writer activity
      rnd_busy = 1'b1;
      repeat (6) begin
         rand_mem();
         sbq.push_back(snap()); pulse_req(); wait_done(1, 1500);
      end
      rnd_busy = 1'b0;
      @(posedge clk); #2 bus.wr_busy = 1'b0;

      // writer holds the bus across the request
      rand_mem();
      @(posedge clk); #1 bus.wr_busy = 1'b1;
      sbq.push_back(snap()); pulse_req();
      repeat (48) @(posedge clk);
      #1 chk("held_busy", 32'(bus.busy), 32'd0);
      chk("held_cs", 32'(bus.sid_cs), 32'd1);
      bus.wr_busy = 1'b0;
      wait_cs(1'b0, 40, cyc);
      chk("release_cs_low", 32'(bus.sid_cs), 32'd0);
      chk("release_latency_ok", 32'(cyc <= 18), 32'd1);
      wait_done(1, 600);

      // writer grabs the bus mid-sweep
      rand_mem();
      sbq.push_back(snap()); pulse_req();
      wait_cs(1'b0, 100, cyc);
      bus.wr_busy = 1'b1;
      wait_cs(1'b1, 20, cyc);
      chk("mid_cycle_completes", 32'(bus.sid_cs), 32'd1);
      lowc = 0;
      repeat (40) begin
         @(negedge clk);
         if (!bus.sid_cs) lowc++;
      end
      chk("stall_no_cs", 32'(lowc), 32'd0);
      chk("stall_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1 bus.wr_busy = 1'b0;
      wait_done(1, 600);

      // three requests during a sweep collapse into one follow-up
      rand_mem();
      sbq.push_back(snap()); sbq.push_back(snap());
      pulse_req();
      repeat (3) begin
         repeat (10) @(posedge clk);
         pulse_req();
      end
      wait_done(2, 1200);
      repeat (200) @(posedge clk);
      #1 chk("coalesce_no_third", 32'(done_cnt), 32'(exp_done));

      // late data on the last phi2-high clk
      late = 1'b1;
      sbq.push_back(snap()); pulse_req(); wait_done(1, 600);
      late = 1'b0;

      // async reset while a read cycle is open
      rand_mem();
      pulse_req();
      wait_cs(1'b0, 100, cyc);
      chk("pre_reset_cs_low", 32'(bus.sid_cs), 32'd0);
      bus.rd_sel = 2'd1;
      #2 rst = 1'b0;
      #1 chk("async_rst_cs", 32'(bus.sid_cs), 32'd1);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_rb_valid", 32'(bus.rb_valid), 32'd0);
      chk("async_rst_rd_data", 32'(bus.rd_data), 32'd0);
      sbq.delete();
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      rand_mem();
      sbq.push_back(snap()); pulse_req(); wait_done(1, 600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
